// File: rtl/processing_mem_stream_mover.sv
// Avalon-MM master on the 16-bit processing-memory port: moves halfword blocks between
// memory and an Avalon-ST source/sink pair under a single-command control interface.
module processing_mem_stream_mover #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 14,
  parameter int MEM_WORDS = 15000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  done_count,
  output logic [ADDR_W-1:0] address2,
  output logic              chipselect2,
  output logic              write2,
  output logic [1:0]        byteenable2,
  output logic [DATA_W-1:0] writedata2,
  output logic              clken2,
  input  logic [DATA_W-1:0] readdata2,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  output logic              src_sop,
  output logic              src_eop,
  input  logic              src_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_RD     = 3'd2,
    S_RDRAIN = 3'd3,
    S_WR     = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic                dir_r;
  logic [ADDR_W-1:0]   cur_r;
  logic [LEN_W-1:0]    len_r, moved_r, iss_r;
  logic                cs_r, we_r, pend_r;
  logic [ADDR_W-1:0]   addr_out_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   fifo_mem_r [2];
  logic                fifo_rd_r, fifo_wr_r;
  logic [1:0]          fifo_cnt_r;
  logic                done_r, error_r, snk_ready_r;
  logic [LEN_W-1:0]    done_count_r;

  logic                cmd_acc_s, range_bad_s, rd_issue_s, rd_last_s;
  logic                wr_acc_s, wr_last_s, push_s, pop_s, zero_done_s;
  logic [LEN_W:0]      span_s;
  logic [2:0]          occ_s;

  assign cmd_acc_s   = cmd_valid && (state_r == S_IDLE);
  assign span_s      = (LEN_W+1)'(cur_r) + (LEN_W+1)'(len_r);
  assign range_bad_s = span_s > (LEN_W+1)'(MEM_WORDS);
  assign zero_done_s = (state_r == S_CHECK) && !range_bad_s && (len_r == LEN_W'(0));
  // Occupancy counts FIFO entries plus reads still in the registered issue/return pipeline
  assign occ_s       = 3'(fifo_cnt_r) + 3'(cs_r) + 3'(pend_r);
  assign rd_issue_s  = (state_r == S_RD) && (occ_s < 3'd2);
  assign rd_last_s   = rd_issue_s && (iss_r == len_r - LEN_W'(1));
  assign wr_acc_s    = (state_r == S_WR) && snk_valid && snk_ready_r;
  assign wr_last_s   = wr_acc_s && (snk_eop || (moved_r == len_r - LEN_W'(1)));
  assign push_s      = pend_r;
  assign pop_s       = (fifo_cnt_r != 2'd0) && src_ready;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (cmd_acc_s) state_s = S_CHECK; else state_s = S_IDLE;
      S_CHECK: begin
        if (range_bad_s)               state_s = S_IDLE;
        else if (len_r == LEN_W'(0))   state_s = S_IDLE;
        else if (dir_r)                state_s = S_WR;
        else                           state_s = S_RD;
      end
      S_RD:     if (rd_last_s) state_s = S_RDRAIN; else state_s = S_RD;
      S_RDRAIN: begin
        if ((fifo_cnt_r == 2'd0) && !cs_r && !pend_r) state_s = S_FIN;
        else                                          state_s = S_RDRAIN;
      end
      S_WR:     if (!snk_ready_r) state_s = S_FIN; else state_s = S_WR;
      S_FIN:    state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Command capture, current address and beat counters; cur stops on the final beat
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_r   <= 1'b0;
      cur_r   <= '0;
      len_r   <= '0;
      moved_r <= '0;
      iss_r   <= '0;
    end else if (cmd_acc_s) begin
      dir_r   <= cmd_dir;
      cur_r   <= cmd_addr;
      len_r   <= cmd_len;
      moved_r <= '0;
      iss_r   <= '0;
    end else begin
      if (rd_issue_s && !rd_last_s)     cur_r <= cur_r + ADDR_W'(1);
      else if (wr_acc_s && !wr_last_s)  cur_r <= cur_r + ADDR_W'(1);
      if (rd_issue_s)                   iss_r <= iss_r + LEN_W'(1);
      if (pop_s || wr_acc_s)            moved_r <= moved_r + LEN_W'(1);
    end
  end

  // Registered memory strobes; pend marks the cycle readdata2 is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_r       <= 1'b0;
      we_r       <= 1'b0;
      pend_r     <= 1'b0;
      addr_out_r <= '0;
      wdata_r    <= '0;
    end else begin
      cs_r   <= rd_issue_s || wr_acc_s;
      we_r   <= wr_acc_s;
      pend_r <= cs_r && !we_r;
      if (rd_issue_s || wr_acc_s) addr_out_r <= cur_r;
      if (wr_acc_s)               wdata_r    <= snk_data;
    end
  end

  // Two-entry skid FIFO for the read path
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      fifo_rd_r     <= 1'b0;
      fifo_wr_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[fifo_wr_r] <= readdata2;
        fifo_wr_r             <= ~fifo_wr_r;
      end
      if (pop_s) fifo_rd_r <= ~fifo_rd_r;
      fifo_cnt_r <= fifo_cnt_r + 2'(push_s) - 2'(pop_s);
    end
  end

  // Completion/error pulses and sink ready
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      done_count_r <= '0;
      snk_ready_r  <= 1'b0;
    end else begin
      done_r  <= (state_r == S_FIN) || zero_done_s;
      error_r <= (state_r == S_CHECK) && range_bad_s;
      if ((state_r == S_FIN) || zero_done_s) done_count_r <= moved_r;
      if ((state_r == S_CHECK) && (state_s == S_WR)) snk_ready_r <= 1'b1;
      else if (wr_last_s)                             snk_ready_r <= 1'b0;
    end
  end

  assign cmd_ready   = (state_r == S_IDLE);
  assign done        = done_r;
  assign error       = error_r;
  assign done_count  = done_count_r;
  assign address2    = addr_out_r;
  assign chipselect2 = cs_r;
  assign write2      = we_r;
  assign byteenable2 = 2'b11;
  assign writedata2  = wdata_r;
  assign clken2      = 1'b1;
  assign snk_ready   = snk_ready_r;
  assign src_valid   = (fifo_cnt_r != 2'd0);
  assign src_data    = fifo_mem_r[fifo_rd_r];
  assign src_sop     = src_valid && (moved_r == LEN_W'(0));
  assign src_eop     = src_valid && (moved_r == len_r - LEN_W'(1));

endmodule
